mem_word_ctrl: RTL and testbench

Access controller placed directly upstream of the word array. It accepts one read or write request at a time over a valid/ready handshake and decodes the address to a one-hot word select. It sequences the word-level `RW`/`select`/data lines so that data and direction are stable before and after the select strobe, captures the read word, and returns a response over a second valid/ready handshake.

---
 rtl/mem_word_ctrl_pkg.sv | 35 +++
 rtl/mem_word_ctrl_decoder.sv | 28 ++
 rtl/mem_word_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mem_word_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_word_ctrl_pkg.sv
// ============================================================================
// Module  : mem_word_ctrl_pkg
// Brief   : Shared types and constants for the word-array access controller.
//           The write-verify states exist only when
//           MEM_WORD_CTRL_WRITE_VERIFY_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_word_ctrl_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    // Polarity of the shared RW line into the word array
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_STROBE   = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_RESP     = 3'd4
`ifdef MEM_WORD_CTRL_WRITE_VERIFY_EN
        ,
        ST_VSETUP   = 3'd5,
        ST_VSTROBE  = 3'd6,
        ST_VRELEASE = 3'd7
`endif
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_word_ctrl_decoder.sv
// ============================================================================
// Module  : mem_addr_decoder
// Brief   : Combinational address to one-hot word select with enable.
//           Output is all-zero when the enable is low.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_addr_decoder #(
    parameter  int ADDR_W = 4,
    localparam int WORDS  = 2**ADDR_W
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              en_i,
    output logic [WORDS-1:0]  sel_o
);

    // One bit set for the addressed word, only while enabled
    always_comb begin
        sel_o = '0;
        if (en_i) begin
            sel_o[addr_i] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_word_ctrl.sv
// ============================================================================
// Module  : mem_word_ctrl
// Brief   : Single-outstanding read/write controller in front of the word
//           array. Sequences RW/data setup, a one-cycle select strobe and a
//           release phase, then presents a response over valid/ready.
//           Optional write readback check: MEM_WORD_CTRL_WRITE_VERIFY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_word_ctrl
    import mem_word_ctrl_pkg::*;
#(
    parameter  int ADDR_W = ADDR_W_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int WORDS  = 2**ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_rw,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic [WORDS-1:0]        mem_sel,
    output logic                    mem_rw,
    output logic [DATA_W-1:0]       mem_din,
    input  logic [WORDS*DATA_W-1:0] mem_dout
);

    state_t              state_q;
    state_t              state_d;
    logic                accept;
    logic                sel_en;
    logic [WORDS-1:0]    sel_d;
    logic [DATA_W-1:0]   rd_word;

    logic                req_ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rw_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORDS-1:0]    mem_sel_q;
    logic                mem_rw_q;
    logic [DATA_W-1:0]   mem_din_q;
`ifdef MEM_WORD_CTRL_WRITE_VERIFY_EN
    logic [DATA_W-1:0]   wdata_q;
    logic                rsp_err_q;
`endif

    // Outputs are registered so the strobe is glitch-free at the array.
    // Enable is taken from the next state so the select register is high
    // exactly while the state register holds a strobe state.
`ifdef MEM_WORD_CTRL_WRITE_VERIFY_EN
    assign sel_en = (state_d == ST_STROBE) || (state_d == ST_VSTROBE);
`else
    assign sel_en = (state_d == ST_STROBE);
`endif

    mem_addr_decoder #(
        .ADDR_W (ADDR_W)
    ) u_dec (
        .addr_i (addr_q),
        .en_i   (sel_en),
        .sel_o  (sel_d)
    );

    assign rd_word = mem_dout[int'(addr_q) * DATA_W +: DATA_W];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and request acceptance
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    accept  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP:   state_d = ST_STROBE;
            ST_STROBE:  state_d = ST_RELEASE;
            ST_RELEASE: begin
`ifdef MEM_WORD_CTRL_WRITE_VERIFY_EN
                state_d = (rw_q == RW_WRITE) ? ST_VSETUP : ST_RESP;
`else
                state_d = ST_RESP;
`endif
            end
`ifdef MEM_WORD_CTRL_WRITE_VERIFY_EN
            ST_VSETUP:   state_d = ST_VSTROBE;
            ST_VSTROBE:  state_d = ST_VRELEASE;
            ST_VRELEASE: state_d = ST_RESP;
`endif
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Request latch, array bus drive, read capture and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rw_q        <= RW_READ;
            addr_q      <= '0;
            mem_sel_q   <= '0;
            mem_rw_q    <= RW_READ;
            mem_din_q   <= '0;
`ifdef MEM_WORD_CTRL_WRITE_VERIFY_EN
            wdata_q     <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            req_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
            mem_sel_q   <= sel_d;
            if (accept) begin
                rw_q        <= req_rw;
                addr_q      <= req_addr;
                mem_rw_q    <= req_rw;
                mem_din_q   <= (req_rw == RW_READ) ? '0 : req_wdata;
                rsp_rdata_q <= '0;
`ifdef MEM_WORD_CTRL_WRITE_VERIFY_EN
                wdata_q     <= req_wdata;
                rsp_err_q   <= 1'b0;
`endif
            end
            if ((state_q == ST_STROBE) && (rw_q == RW_READ)) begin
                rsp_rdata_q <= rd_word;
            end
`ifdef MEM_WORD_CTRL_WRITE_VERIFY_EN
            // Turn the bus around to read only after the write select dropped
            if ((state_q == ST_RELEASE) && (rw_q == RW_WRITE)) begin
                mem_rw_q  <= RW_READ;
                mem_din_q <= '0;
            end
            if (state_q == ST_VSTROBE) begin
                rsp_rdata_q <= rd_word;
                rsp_err_q   <= (rd_word != wdata_q);
            end
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_sel   = mem_sel_q;
    assign mem_rw    = mem_rw_q;
    assign mem_din   = mem_din_q;
`ifdef MEM_WORD_CTRL_WRITE_VERIFY_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_word_ctrl.sv
// ============================================================================
// Module  : tb_mem_word_ctrl
// Brief   : Self-checking bench for mem_word_ctrl with a word-array model
//           (optional stuck-at-0 bits) and a scoreboard of expected contents.
//           Adapts its expectations to MEM_WORD_CTRL_WRITE_VERIFY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_word_ctrl;

`ifdef MEM_WORD_CTRL_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_rw = 1'b1;
    logic [3:0]   req_addr = '0;
    logic [7:0]   req_wdata = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [7:0]   rsp_rdata;
    logic         rsp_err;
    logic [15:0]  mem_sel;
    logic         mem_rw;
    logic [7:0]   mem_din;
    logic [127:0] mem_dout;

    int checks   = 0;
    int failures = 0;

    mem_word_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_sel   (mem_sel),
        .mem_rw    (mem_rw),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    // ---------------- word array model ----------------
    logic [7:0] arr      [16];
    logic [7:0] init_val [16];
    logic [7:0] stuck    [16];
    logic       mem_init = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 16; k++) begin
            if (mem_init) arr[k] <= init_val[k];
            else if (mem_sel[k] && mem_rw == 1'b0) arr[k] <= mem_din & ~stuck[k];
        end
    end

    always_comb begin
        mem_dout = '0;
        for (int k = 0; k < 16; k++) mem_dout[k*8 +: 8] = arr[k];
    end

    // ---------------- bus-rule monitor ----------------
    int          cyc = 0;
    int          mon_viol = 0;
    logic [15:0] p_sel = '0;
    logic        p_rw = 1'b1;
    logic [7:0]  p_din = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if ((mem_sel & (mem_sel - 16'd1)) != 16'd0) mon_viol = mon_viol + 1;
            if (req_ready && rsp_valid) mon_viol = mon_viol + 1;
            if ((mem_sel != 16'd0 || p_sel != 16'd0) && (mem_rw != p_rw || mem_din != p_din))
                mon_viol = mon_viol + 1;
        end
        p_sel = mem_sel;
        p_rw  = mem_rw;
        p_din = mem_din;
    end

    // ---------------- scoreboard / reference ----------------
    logic [7:0] exp_mem [16];

    task automatic model(input logic rw, input logic [3:0] a, input logic [7:0] wd,
                         output logic [7:0] rd, output logic er, output int lat);
        logic [7:0] stored;
        if (rw) begin
            rd = exp_mem[a]; er = 1'b0; lat = 4;
        end else begin
            stored     = wd & ~stuck[a];
            exp_mem[a] = stored;
            rd  = VERIFY ? stored : 8'h00;
            er  = VERIFY ? (stored != wd) : 1'b0;
            lat = VERIFY ? 7 : 4;
        end
    endtask

    // Expected array-bus values i cycles after the accept edge
    function automatic void exp_bus(input logic rw, input logic [3:0] a, input logic [7:0] wd,
                                    input int i, output logic [15:0] s,
                                    output logic r, output logic [7:0] d);
        logic vw;
        vw = VERIFY && !rw;
        s  = (i == 1 || (vw && i == 4)) ? (16'd1 << a) : 16'd0;
        r  = (vw && i >= 3) ? 1'b1 : rw;
        d  = (vw && i >= 3) ? 8'h00 : (rw ? 8'h00 : wd);
    endfunction

    // ---------------- transaction driver ----------------
    logic [15:0] t_sel [20];
    logic        t_rw  [20];
    logic [7:0]  t_din [20];
    logic [7:0]  o_rd;
    logic        o_er;
    int          o_lat, o_wait, o_acc;
    logic        o_hold_ok, o_post_ok;

    task automatic txn(input logic rw, input logic [3:0] a, input logic [7:0] wd,
                       input int hold, input logic keep_req);
        req_rw = rw; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        o_wait = 0; o_lat = -1; o_rd = '0; o_er = 1'b0; o_hold_ok = 1'b1; o_post_ok = 1'b0;
        while (!req_ready && o_wait < 50) begin @(posedge clk); #1; o_wait++; end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        o_acc = cyc;
        req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            t_sel[i] = mem_sel; t_rw[i] = mem_rw; t_din[i] = mem_din;
            if (rsp_valid) begin o_lat = i + 1; break; end
            @(posedge clk); #1;
        end
        if (o_lat < 0) begin
            checks++; failures++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
            return;
        end
        o_rd = rsp_rdata; o_er = rsp_err;
        if (keep_req) begin req_valid = 1'b1; req_rw = ~rw; req_addr = a + 4'd1; end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_rdata !== o_rd || rsp_err !== o_er || req_ready) o_hold_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        o_post_ok = (req_ready === 1'b1) && (rsp_valid === 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1; mem_init = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        mem_init = 1'b0;
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, mem_sel, mem_rw, mem_din} !== {1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b1, 8'h00}) begin
            failures++;
            $display("FAIL reset_values: rdy=%b vld=%b rd=%h err=%b sel=%h rw=%b din=%h required 0 0 00 0 0000 1 00",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, mem_sel, mem_rw, mem_din);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset: got %b required 1", req_ready); end
    endtask

    task automatic test_read0;
        logic [7:0] erd; logic eer; int elat; logic [15:0] s; logic r; logic [7:0] d;
        model(1'b1, 4'd0, 8'h00, erd, eer, elat);
        txn(1'b1, 4'd0, 8'h00, 0, 1'b0);
        checks++;
        if (o_lat !== elat) begin failures++; $display("FAIL read0_latency: got %0d required %0d", o_lat, elat); end
        checks++;
        if (o_rd !== erd || o_er !== eer) begin failures++; $display("FAIL read0_data: got %h/%b required %h/%b", o_rd, o_er, erd, eer); end
        for (int i = 0; i < elat; i++) begin
            exp_bus(1'b1, 4'd0, 8'h00, i, s, r, d);
            checks++;
            if (t_sel[i] !== s || t_rw[i] !== r || t_din[i] !== d) begin
                failures++; $display("FAIL read0_bus[%0d]: sel=%h rw=%b din=%h required %h %b %h", i, t_sel[i], t_rw[i], t_din[i], s, r, d);
            end
        end
    endtask

    task automatic test_write_read9;
        logic [7:0] erd; logic eer; int elat; logic [15:0] s; logic r; logic [7:0] d;
        model(1'b0, 4'd9, 8'hA5, erd, eer, elat);
        txn(1'b0, 4'd9, 8'hA5, 0, 1'b0);
        checks++;
        if (o_lat !== elat || o_rd !== erd || o_er !== eer) begin
            failures++; $display("FAIL write9_rsp: lat=%0d rd=%h err=%b required %0d %h %b", o_lat, o_rd, o_er, elat, erd, eer);
        end
        for (int i = 0; i < elat; i++) begin
            exp_bus(1'b0, 4'd9, 8'hA5, i, s, r, d);
            checks++;
            if (t_sel[i] !== s || t_rw[i] !== r || t_din[i] !== d) begin
                failures++; $display("FAIL write9_bus[%0d]: sel=%h rw=%b din=%h required %h %b %h", i, t_sel[i], t_rw[i], t_din[i], s, r, d);
            end
        end
        model(1'b1, 4'd9, 8'h00, erd, eer, elat);
        txn(1'b1, 4'd9, 8'h00, 0, 1'b0);
        checks++;
        if (o_rd !== 8'hA5 || o_lat !== elat) begin failures++; $display("FAIL read9: rd=%h lat=%0d required a5 %0d", o_rd, o_lat, elat); end
    endtask

    task automatic test_hold;
        logic [7:0] erd; logic eer; int elat;
        model(1'b1, 4'd9, 8'h00, erd, eer, elat);
        txn(1'b1, 4'd9, 8'h00, 10, 1'b1);
        checks++;
        if (o_rd !== erd) begin failures++; $display("FAIL hold_data: got %h required %h", o_rd, erd); end
        checks++;
        if (o_hold_ok !== 1'b1) begin failures++; $display("FAIL hold_stable: got %b required 1", o_hold_ok); end
        checks++;
        if (o_post_ok !== 1'b1) begin failures++; $display("FAIL hold_release: ready=%b valid=%b required 1 0", req_ready, rsp_valid); end
        model(1'b1, 4'd2, 8'h00, erd, eer, elat);
        txn(1'b1, 4'd2, 8'h00, 0, 1'b0);
        checks++;
        if (o_wait !== 0 || o_rd !== erd) begin failures++; $display("FAIL hold_next: wait=%0d rd=%h required 0 %h", o_wait, o_rd, erd); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] erd; logic eer; int elat; int acc1; logic [3:0] a;
        a = 4'($urandom_range(0, 15));
        model(1'b1, a, 8'h00, erd, eer, elat);
        txn(1'b1, a, 8'h00, 0, 1'b0);
        acc1 = o_acc;
        a = 4'($urandom_range(0, 15));
        model(1'b1, a, 8'h00, erd, eer, elat);
        txn(1'b1, a, 8'h00, 0, 1'b0);
        checks++;
        if (o_acc - acc1 !== 5) begin failures++; $display("FAIL b2b_period: got %0d required 5", o_acc - acc1); end
        checks++;
        if (o_rd !== erd) begin failures++; $display("FAIL b2b_data: got %h required %h", o_rd, erd); end
    endtask

    task automatic test_reset_mid;
        req_rw = 1'b0; req_addr = 4'd3; req_wdata = 8'h3C; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_sel !== 16'h0008) begin failures++; $display("FAIL mid_strobe_sel: got %h required 0008", mem_sel); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (mem_sel !== 16'h0 || mem_rw !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL mid_reset_async: sel=%h rw=%b vld=%b required 0000 1 0", mem_sel, mem_rw, rsp_valid);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_ready: got %b required 1", req_ready); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rsp_valid !== 1'b0 || mem_sel !== 16'h0) begin
                failures++; $display("FAIL mid_no_rsp: vld=%b sel=%h required 0 0000", rsp_valid, mem_sel);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_verify;
        logic [7:0] erd; logic eer; int elat; logic [15:0] s; logic r; logic [7:0] d;
        stuck[5] = 8'h04;
        model(1'b0, 4'd5, 8'hFF, erd, eer, elat);
        txn(1'b0, 4'd5, 8'hFF, 0, 1'b0);
        checks++;
        if (o_lat !== elat || o_rd !== erd || o_er !== eer) begin
            failures++; $display("FAIL verify_ff: lat=%0d rd=%h err=%b required %0d %h %b", o_lat, o_rd, o_er, elat, erd, eer);
        end
        for (int i = 0; i < elat; i++) begin
            exp_bus(1'b0, 4'd5, 8'hFF, i, s, r, d);
            checks++;
            if (t_sel[i] !== s || t_rw[i] !== r || t_din[i] !== d) begin
                failures++; $display("FAIL verify_bus[%0d]: sel=%h rw=%b din=%h required %h %b %h", i, t_sel[i], t_rw[i], t_din[i], s, r, d);
            end
        end
        model(1'b0, 4'd5, 8'h00, erd, eer, elat);
        txn(1'b0, 4'd5, 8'h00, 0, 1'b0);
        checks++;
        if (o_rd !== erd || o_er !== eer) begin failures++; $display("FAIL verify_00: rd=%h err=%b required %h %b", o_rd, o_er, erd, eer); end
        stuck[5] = 8'h00;
    endtask

    task automatic test_walk;
        logic [7:0] erd, wd; logic eer; int elat;
        mon_viol = 0;
        for (int a = 0; a < 16; a++) begin
            wd = (a % 2 == 0) ? 8'h55 : 8'hAA;
            model(1'b0, 4'(a), wd, erd, eer, elat);
            txn(1'b0, 4'(a), wd, 0, 1'b0);
            model(1'b1, 4'(a), 8'h00, erd, eer, elat);
            txn(1'b1, 4'(a), 8'h00, 0, 1'b0);
            checks++;
            if (o_rd !== wd || o_rd !== erd) begin failures++; $display("FAIL walk[%0d]: got %h required %h", a, o_rd, wd); end
        end
        checks++;
        if (mon_viol !== 0) begin failures++; $display("FAIL bus_rules_walk: violations=%0d required 0", mon_viol); end
    endtask

    task automatic test_random;
        logic [7:0] erd, wd; logic eer, rw; int elat, hold; logic [3:0] a;
        mon_viol = 0;
        for (int n = 0; n < 40; n++) begin
            rw   = 1'($urandom_range(0, 1));
            a    = 4'($urandom_range(0, 15));
            wd   = 8'($urandom_range(0, 255));
            hold = $urandom_range(0, 3);
            model(rw, a, wd, erd, eer, elat);
            txn(rw, a, wd, hold, 1'b0);
            checks++;
            if (o_lat !== elat || o_rd !== erd || o_er !== eer || o_hold_ok !== 1'b1 || o_post_ok !== 1'b1) begin
                failures++;
                $display("FAIL random[%0d] rw=%b a=%0d: lat=%0d rd=%h err=%b hold=%b post=%b required %0d %h %b 1 1",
                         n, rw, a, o_lat, o_rd, o_er, o_hold_ok, o_post_ok, elat, erd, eer);
            end
        end
        checks++;
        if (mon_viol !== 0) begin failures++; $display("FAIL bus_rules_random: violations=%0d required 0", mon_viol); end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            init_val[k] = 8'($urandom_range(0, 255));
            exp_mem[k]  = init_val[k];
            stuck[k]    = 8'h00;
        end
        test_reset();
        test_read0();
        test_write_read9();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_verify();
        test_walk();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
